spi_frame_ctrl: RTL
===================

Name: spi_frame_ctrl

Overview:
- Master-side controller for the 40-bit SPI link to the in-CPU SPI slave.
- Arbitrates two frame requesters (req0 = instruction/config load, req1 = data/status readback) onto one SPI bus, with round-robin fairness.
- Generates sclk, cs_n and mosi for each frame and shifts one full-duplex frame per grant.
- Returns the captured miso frame to the requester that owned the transfer.

Parameters:
- FRAME_W, 40, bits per frame (≥2), MSB first.
- CLK_DIV, 4, clk cycles per sclk half-period (≥1).

Ports:
- clk  in  1  system clock
- rstn  in  1  reset; synchronous, active-low
- req0_valid  in  1  requester 0 has a frame
- req0_data  in  FRAME_W  requester 0 transmit frame
- req0_ready  out  1  one-cycle accept pulse for requester 0
- req1_valid  in  1  requester 1 has a frame
- req1_data  in  FRAME_W  requester 1 transmit frame
- req1_ready  out  1  one-cycle accept pulse for requester 1
- rsp_valid  out  1  one-cycle pulse: received frame available
- rsp_data  out  FRAME_W  received frame; held until next rsp_valid
- rsp_id  out  1  requester that owned the frame; held with rsp_data
- busy  out  1  high in every state except IDLE
- sclk  out  1  SPI clock, mode 0 (idle low)
- cs_n  out  1  chip select, active low
- mosi  out  1  serial data out
- miso  in  1  serial data in

Behaviour:
- Reset: synchronous on posedge clk while rstn=0.
  - State goes to IDLE; divider, bit counter, shift registers and rsp_data are cleared.
  - sclk=0, cs_n=1, mosi=0, rsp_valid=0, rsp_id=0, req*_ready=0, busy=0.
  - The round-robin pointer is set so that req0 wins the first tie.
  - Reset mid-frame aborts the frame: cs_n is high after that edge, and no rsp_valid is issued for the aborted frame.
- States: IDLE, SETUP, SHIFT, HOLD, GAP.
- IDLE:
  - If any reqN_valid is high, grant a requester:
    - Only one valid: that requester wins.
    - Both valid: the requester not granted last wins.
  - Grant cycle: the winner's reqN_ready=1 for exactly this cycle, its data is loaded into the tx shift register, its id is latched, and the pointer is updated. Next state is SETUP.
  - The requester must hold valid/data stable until ready. A valid that drops before a grant is never granted.
- SETUP:
  - Lasts CLK_DIV cycles.
  - cs_n=0, sclk=0, mosi = tx bit FRAME_W-1.
- SHIFT:
  - Lasts 2·FRAME_W·CLK_DIV cycles; sclk toggles every CLK_DIV cycles.
  - sclk rising edge: sample miso into the rx shift register LSB, shifting left.
  - sclk falling edge: shift tx and drive the next bit on mosi. No shift after the last bit.
  - After FRAME_W rising and FRAME_W falling edges, go to HOLD with sclk=0.
- HOLD:
  - Lasts CLK_DIV cycles.
  - cs_n=0, sclk=0, mosi holds the last bit.
- GAP:
  - Lasts CLK_DIV cycles; cs_n=1, mosi=0.
  - First GAP cycle: rsp_valid=1, rsp_data = rx register, rsp_id = latched id.
  - Then return to IDLE. No grant occurs during GAP.
- Latency: grant at cycle T → cs_n falls at T+1 → rsp_valid at T+1+CLK_DIV·(2·FRAME_W+2).
  - Default parameters: T+329.
  - Earliest next grant: rsp_valid cycle + CLK_DIV.
- Exactly one reqN_ready per frame, and exactly one rsp_valid per completed frame. req0_ready and req1_ready are never high together.
- rsp_valid has no backpressure; consumers must capture it in the pulse cycle.
- cs_n is glitch-free, and sclk is low whenever cs_n transitions.

Test Plan:
1. Single transfer, loopback: miso tied to mosi, req0_data=40'hA5_1234_5678 → req0_ready pulses once; rsp_valid at grant+329; rsp_data=40'hA5_1234_5678; rsp_id=0; exactly 40 sclk rising edges while cs_n=0.
2. Simultaneous requests from reset: both valid, req0=40'h1, req1=40'h2, loopback → req0 granted first (rsp_id=0, data 40'h1), then req1 (rsp_id=1, data 40'h2); the two ready pulses are 333 cycles apart.
3. Fairness under load: both valid continuously for 6 frames → grants alternate 0,1,0,1,0,1; no requester is granted twice in a row.
4. Fixed slave pattern: miso driven by a model returning 40'hF0F0_0F0F_AA on rising edges → rsp_data=40'hF0F0_0F0F_AA. A mosi checker samples on sclk rising edges and confirms MSB-first transmit.
5. Reset mid-SHIFT: rstn=0 for one cycle after 10 sclk edges → next cycle cs_n=1, sclk=0, busy=0; no rsp_valid; the next request completes normally.
6. CLK_DIV=1, FRAME_W=8: loopback 8'h3C → rsp_data=8'h3C; rsp_valid at grant+1+18; sclk period is 2 clk.

Source files
------------

// File: rtl/spi_frame_ctrl.sv
// Master-side SPI frame controller: round-robin arbitration of two frame
// requesters onto one mode-0 SPI link, full-duplex shift, response return.
module spi_frame_ctrl #(
  parameter int FRAME_W = 40,
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               req0_valid,
  input  logic [FRAME_W-1:0] req0_data,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [FRAME_W-1:0] req1_data,
  output logic               req1_ready,
  output logic               rsp_valid,
  output logic [FRAME_W-1:0] rsp_data,
  output logic               rsp_id,
  output logic               busy,
  output logic               sclk,
  output logic               cs_n,
  output logic               mosi,
  input  logic               miso
);

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGES  = 2 * FRAME_W;
  localparam int EDGE_W = $clog2(EDGES + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  typedef struct packed {
    logic               id;
    logic [FRAME_W-1:0] data;
  } frame_t;

  state_t             state, state_nx;
  logic [DIV_W-1:0]   div_cnt;
  logic [EDGE_W-1:0]  edge_cnt;
  logic [FRAME_W-1:0] tx_sr, rx_sr, grant_data;
  logic               cur_id, last_id;
  logic               sclk_q, cs_n_q, mosi_q, rsp_valid_q;
  frame_t             rsp_q;
  logic               div_done, last_edge, grant0, grant1, grant, rise, fall;

  assign div_done  = div_cnt == DIV_W'(CLK_DIV - 1);
  assign last_edge = edge_cnt == EDGE_W'(EDGES);

  // last_id remembers the previous winner; the other requester wins a tie
  assign grant0     = req0_valid & (~req1_valid | last_id);
  assign grant1     = req1_valid & ~grant0;
  assign grant      = (state == IDLE) & (grant0 | grant1);
  assign grant_data = grant1 ? req1_data : req0_data;

  // First rising edge is issued as SETUP ends; the rest alternate inside SHIFT
  // until all 2*FRAME_W edges are done, leaving sclk low for HOLD.
  assign rise = (state == SETUP && div_done) ||
                (state == SHIFT && div_done && !last_edge && !sclk_q);
  assign fall = state == SHIFT && div_done && !last_edge && sclk_q;

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (grant0 | grant1) begin
          state_nx   = SETUP;
          req0_ready = grant0;
          req1_ready = grant1;
        end
      end
      SETUP:   if (div_done)              state_nx = SHIFT;
      SHIFT:   if (div_done && last_edge) state_nx = HOLD;
      HOLD:    if (div_done)              state_nx = GAP;
      GAP:     if (div_done)              state_nx = IDLE;
      default:                            state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      div_cnt     <= '0;
      edge_cnt    <= '0;
      tx_sr       <= '0;
      rx_sr       <= '0;
      cur_id      <= 1'b0;
      last_id     <= 1'b1;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (state == IDLE) div_cnt <= '0;
      else               div_cnt <= div_done ? '0 : div_cnt + DIV_W'(1);

      if (grant) begin
        tx_sr    <= grant_data;
        mosi_q   <= grant_data[FRAME_W-1];
        cur_id   <= grant1;
        last_id  <= grant1;
        cs_n_q   <= 1'b0;
        edge_cnt <= '0;
      end

      if (rise) begin
        sclk_q   <= 1'b1;
        rx_sr    <= {rx_sr[FRAME_W-2:0], miso};
        edge_cnt <= edge_cnt + EDGE_W'(1);
      end

      if (fall) begin
        sclk_q   <= 1'b0;
        edge_cnt <= edge_cnt + EDGE_W'(1);
        // the final falling edge leaves the last bit on mosi through HOLD
        if (edge_cnt != EDGE_W'(EDGES - 1)) begin
          tx_sr  <= {tx_sr[FRAME_W-2:0], 1'b0};
          mosi_q <= tx_sr[FRAME_W-2];
        end
      end

      if (state == HOLD && div_done) begin
        cs_n_q      <= 1'b1;
        mosi_q      <= 1'b0;
        rsp_valid_q <= 1'b1;
        rsp_q       <= '{id: cur_id, data: rx_sr};
      end
    end
  end

  assign sclk      = sclk_q;
  assign cs_n      = cs_n_q;
  assign mosi      = mosi_q;
  assign busy      = state != IDLE;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_q.data;
  assign rsp_id    = rsp_q.id;

endmodule
